// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic phase controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } state_e;

    // Lamp triplet per approach: {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/rr_phase_select.sv
// Round-robin pick of the next pending phase, scanning from cur+1 with wrap.
module rr_phase_select #(
    parameter int NUM_PHASES = 4
) (
    input  logic [NUM_PHASES-1:0]         pend,
    input  logic [$clog2(NUM_PHASES)-1:0] cur,
    output logic [$clog2(NUM_PHASES)-1:0] sel,
    output logic                          found
);

    localparam int PW = $clog2(NUM_PHASES);

    int            idx;
    logic [PW-1:0] ix;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        ix    = '0;
        // The last step (k == NUM_PHASES) revisits cur itself.
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = (int'(cur) + k) % NUM_PHASES;
            ix  = PW'(idx);
            if (!found && pend[ix]) begin
                found = 1'b1;
                sel   = ix;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach signal sequencer with demand skipping, emergency pre-emption
// and night flashing; all outputs are registered.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int T_GREEN    = 7,
    parameter int T_YELLOW   = 2,
    parameter int T_ALLRED   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PHASES-1:0]         req,
    input  logic                          emerg,
    input  logic [$clog2(NUM_PHASES)-1:0] emerg_phase,
    input  logic                          flash_mode,
    output logic [3*NUM_PHASES-1:0]       light,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic [1:0]                    state_o
);

    localparam int PW = $clog2(NUM_PHASES);

    localparam logic [1:0] S_GREEN  = ST_GREEN;
    localparam logic [1:0] S_YELLOW = ST_YELLOW;
    localparam logic [1:0] S_ALLRED = ST_ALLRED;
    localparam logic [1:0] S_FLASH  = ST_FLASH;

    logic [1:0]                  state, state_d;
    logic [CNT_W-1:0]            timer, timer_d;
    logic [PW-1:0]               phase_d, next_seq, rr_phase;
    logic [NUM_PHASES-1:0]       pend, pend_d, grn_clr;
    logic                        flash_tgl, flash_tgl_d;
    logic                        emerg_v, rr_found;
    logic                        grn_end, yel_end, red_end;
    logic [NUM_PHASES-1:0][2:0]  lamp_d;

    // Out-of-range emergency phase is ignored entirely.
    assign emerg_v  = emerg && (32'(emerg_phase) < NUM_PHASES);
    assign grn_end  = (timer == CNT_W'(T_GREEN - 1));
    assign yel_end  = (timer == CNT_W'(T_YELLOW - 1));
    assign red_end  = (timer == CNT_W'(T_ALLRED - 1));
    assign next_seq = (32'(active_phase) == NUM_PHASES - 1) ? '0 : active_phase + 1'b1;

    rr_phase_select #(
        .NUM_PHASES (NUM_PHASES)
    ) u_rr (
        .pend  (pend),
        .cur   (active_phase),
        .sel   (rr_phase),
        .found (rr_found)
    );

    always_comb begin
        state_d = state;
        timer_d = timer + 1'b1;
        phase_d = active_phase;
        case (state)
            S_GREEN: begin
                if (emerg_v && emerg_phase != active_phase)
                    state_d = S_YELLOW;
                else if (emerg_v)
                    timer_d = '0;  // hold so a full green runs after release
                else if (grn_end)
                    state_d = S_YELLOW;
            end
            S_YELLOW: begin
                if (yel_end)
                    state_d = S_ALLRED;
            end
            S_ALLRED: begin
                if (red_end) begin
                    if (emerg_v) begin
                        state_d = S_GREEN;
                        phase_d = emerg_phase;
                    end else if (flash_mode) begin
                        state_d = S_FLASH;
                    end else begin
                        state_d = S_GREEN;
                        phase_d = rr_found ? rr_phase : next_seq;
                    end
                end
            end
            default: begin
                timer_d = '0;
                if (!flash_mode || emerg_v)
                    state_d = S_ALLRED;
            end
        endcase
        if (state_d != state)
            timer_d = '0;
    end

    // Served phase drops its demand on green entry; a same-cycle req re-arms it.
    assign grn_clr = (state_d == S_GREEN && state != S_GREEN) ?
                     ({{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_d) : '0;
    assign pend_d  = (pend & ~grn_clr) | req;

    assign flash_tgl_d = (state_d == S_FLASH) ? ((state != S_FLASH) ? 1'b1 : ~flash_tgl) : 1'b0;

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lamp
        assign lamp_d[i] = (state_d == S_FLASH)  ? (flash_tgl_d ? LAMP_YEL : LAMP_OFF) :
                           (phase_d != PW'(i))   ? LAMP_RED :
                           (state_d == S_GREEN)  ? LAMP_GRN :
                           (state_d == S_YELLOW) ? LAMP_YEL : LAMP_RED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ALLRED;
            timer        <= '0;
            active_phase <= PW'(NUM_PHASES - 1);
            pend         <= '0;
            flash_tgl    <= 1'b0;
            light        <= {NUM_PHASES{LAMP_RED}};
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            active_phase <= phase_d;
            pend         <= pend_d;
            flash_tgl    <= flash_tgl_d;
            light        <= lamp_d;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench: fixed-time vector table plus hand sequences for skip,
// pre-emption, flash, invalid emergency and mid-run reset.
module tb_traffic_phase_controller;

    localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, F = 2'd3;

    logic        clk = 1'b0;
    logic        rst, emerg, flash;
    logic [3:0]  req;
    logic [1:0]  eph, aph, st;
    logic [11:0] light;

    logic        rst5, emerg5, flash5;
    logic [4:0]  req5;
    logic [2:0]  eph5, aph5;
    logic [1:0]  st5;
    logic [14:0] light5;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk (clk), .rst (rst), .req (req), .emerg (emerg), .emerg_phase (eph),
        .flash_mode (flash), .light (light), .active_phase (aph), .state_o (st)
    );

    traffic_phase_controller #(.NUM_PHASES(5)) dut5 (
        .clk (clk), .rst (rst5), .req (req5), .emerg (emerg5), .emerg_phase (eph5),
        .flash_mode (flash5), .light (light5), .active_phase (aph5), .state_o (st5)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       emerg;
        logic [1:0] eph;
        logic       flash;
        logic [1:0] st;
        int         ph;
    } vec_t;

    vec_t tbl [43];

    function automatic logic [14:0] exp_lights(input logic [1:0] s, input int ph,
                                               input logic tgl, input int n);
        logic [14:0] l;
        l = '0;
        for (int i = 0; i < n; i++) begin
            case (s)
                G:       l[3*i +: 3] = (i == ph) ? 3'b001 : 3'b100;
                Y:       l[3*i +: 3] = (i == ph) ? 3'b010 : 3'b100;
                R:       l[3*i +: 3] = 3'b100;
                default: l[3*i +: 3] = tgl ? 3'b010 : 3'b000;
            endcase
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string nm, input logic [1:0] es, input int ep, input logic tgl);
        logic [14:0] el;
        el = exp_lights(es, ep, tgl, 4);
        vec_cnt++;
        if (st !== es || aph !== 2'(ep) || light !== el[11:0]) begin
            miss_cnt++;
            $display("FAIL %s #%0d: got state=%0d phase=%0d light=%b, want state=%0d phase=%0d light=%b",
                     nm, vec_cnt, st, aph, light, es, ep, el[11:0]);
        end
    endtask

    task automatic chk5(input string nm, input logic [1:0] es, input int ep);
        logic [14:0] el;
        el = exp_lights(es, ep, 1'b0, 5);
        vec_cnt++;
        if (st5 !== es || aph5 !== 3'(ep) || light5 !== el) begin
            miss_cnt++;
            $display("FAIL %s #%0d: got state=%0d phase=%0d light=%b, want state=%0d phase=%0d light=%b",
                     nm, vec_cnt, st5, aph5, light5, es, ep, el);
        end
    endtask

    task automatic run4(input string nm, input logic [1:0] es, input int ep, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk4(nm, es, ep, 1'b0);
        end
    endtask

    task automatic do_reset4();
        req = '0; emerg = 1'b0; eph = '0; flash = 1'b0;
        rst = 1'b1;
        run4("reset", R, 3, 2);
        rst = 1'b0;
    endtask

    task automatic run_phase4(input string nm, input int ph);
        run4(nm, G, ph, 7);
        run4(nm, Y, ph, 2);
        run4(nm, R, ph, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; emerg = 1'b0; eph = '0; flash = 1'b0;
        rst5 = 1'b1; req5 = '0; emerg5 = 1'b0; eph5 = '0; flash5 = 1'b0;

        // Reset for two edges, then 41 free-running edges of fixed-time cycling.
        for (int i = 0; i < 2; i++) tbl[i] = '{1'b1, 4'b0, 1'b0, 2'd0, 1'b0, R, 3};
        for (int k = 1; k <= 41; k++) begin
            int o;
            o = (k - 1) % 10;
            tbl[k+1] = '{1'b0, 4'b0, 1'b0, 2'd0, 1'b0,
                         (o < 7) ? G : (o < 9) ? Y : R, ((k - 1) / 10) % 4};
        end
        for (int i = 0; i < 43; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; emerg = tbl[i].emerg;
            eph = tbl[i].eph; flash = tbl[i].flash;
            tick();
            chk4("fixed", tbl[i].st, tbl[i].ph, 1'b0);
        end

        // Demand skip: phase 1 skipped, pend[2] cleared once served.
        do_reset4();
        run4("skip", G, 0, 1);
        req = 4'b0100;
        run4("skip", G, 0, 1);
        req = 4'b0000;
        run4("skip", G, 0, 5);
        run4("skip", Y, 0, 2);
        run4("skip", R, 0, 1);
        run_phase4("skip", 2);
        run4("skip_clr", G, 3, 1);

        // Emergency pre-emption at timer 3 of phase 0 green.
        do_reset4();
        run4("emerg", G, 0, 4);
        emerg = 1'b1; eph = 2'd3;
        run4("emerg", Y, 0, 2);
        run4("emerg", R, 0, 1);
        run4("emerg_hold", G, 3, 5);
        emerg = 1'b0;
        run4("emerg_rel", G, 3, 6);
        run4("emerg_rel", Y, 3, 1);

        // Flash mode requested during phase 1 green.
        do_reset4();
        run_phase4("flash", 0);
        run4("flash", G, 1, 1);
        flash = 1'b1;
        run4("flash", G, 1, 6);
        run4("flash", Y, 1, 2);
        run4("flash", R, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4("flash_tgl", F, 1, (i % 2 == 0));
        end
        flash = 1'b0;
        run4("flash_exit", R, 1, 1);
        run4("flash_exit", G, 2, 1);

        // Reset mid-operation during phase 2 yellow with pend=1010.
        do_reset4();
        run_phase4("midrst", 0);
        run_phase4("midrst", 1);
        run4("midrst", G, 2, 1);
        req = 4'b1010;
        run4("midrst", G, 2, 1);
        req = 4'b0000;
        run4("midrst", G, 2, 5);
        run4("midrst", Y, 2, 1);
        rst = 1'b1;
        run4("midrst_rst", R, 3, 1);
        rst = 1'b0;
        run4("midrst_restart", G, 0, 7);
        run4("midrst_restart", Y, 0, 2);

        // Invalid emergency on a 5-phase instance: fixed-time sequence unchanged.
        rst5 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk5("inv_reset", R, 4);
        end
        rst5 = 1'b0; emerg5 = 1'b1; eph5 = 3'd7;
        for (int k = 1; k <= 51; k++) begin
            int o;
            o = (k - 1) % 10;
            tick();
            chk5("inv_emerg", (o < 7) ? G : (o < 9) ? Y : R, ((k - 1) / 10) % 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised N-approach traffic-signal sequencer: the next-generation junction controller. It replaces fixed-approach, fixed-timing sequencing with a configurable phase count and configurable green/yellow/all-red durations. It adds demand-actuated phase skipping, emergency pre-emption and a night flashing mode. It sits directly behind the junction's slow tick clock and drives the lamp outputs of every approach.

## Interface
- NUM_PHASES, 4: number of approaches/phases; must be ≥2.
- CNT_W, 8: width of the dwell timer.
- T_GREEN, 7: green dwell in clk cycles; must be 1..2^CNT_W-1.
- T_YELLOW, 2: yellow dwell in cycles; same range rule as T_GREEN.
- T_ALLRED, 1: all-red clearance in cycles; same range rule as T_GREEN.
- clk input 1: single clock, rising edge.
- rst input 1: synchronous, active-high reset.
- req input NUM_PHASES: vehicle demand per phase, level or pulse.
- emerg input 1: emergency pre-emption request.
- emerg_phase input $clog2(NUM_PHASES): phase to serve during an emergency.
- flash_mode input 1: request night flashing mode.
- light output 3*NUM_PHASES: lamps of phase i at light[3*i +: 3] = {red, yellow, green}.
- active_phase output $clog2(NUM_PHASES): currently selected phase.
- state_o output 2: current FSM state.

## Operation
- State encoding: GREEN=0, YELLOW=1, ALLRED=2, FLASH=3.
- The dwell timer counts up from 0. A state exits when timer == T_x-1; timer clears on every state change.
- Lamp rules:
  - GREEN: the active phase shows 001 and all other phases show 100.
  - YELLOW: the active phase shows 010 and all other phases show 100.
  - ALLRED: all phases show 100.
  - FLASH: all phases show 010 when flash_tgl=1 and 000 when flash_tgl=0. flash_tgl is 1 on the first FLASH cycle, then toggles every cycle.
- Pending register pend[NUM_PHASES]:
  - pend |= req every cycle.
  - pend[active_phase] clears on the cycle GREEN is entered for that phase.
  - If req is high on that same cycle, set wins; the phase is served again later.
- Next-phase choice is made at ALLRED exit, in this priority order:
  1. emerg=1 with a valid emerg_phase: go to that phase.
  2. flash_mode=1: go to FLASH.
  3. Otherwise: the first phase with pend set, scanning round-robin from active_phase+1 with wrap. If no phase is pending, use active_phase+1 mod NUM_PHASES (fixed-time fallback).
- Emergency handling:
  - In GREEN of a phase other than emerg_phase: go to YELLOW on the next edge, regardless of timer.
  - In GREEN of emerg_phase: the timer is held at 0 while emerg=1, so a full T_GREEN runs after release.
  - In YELLOW or ALLRED: the state runs to completion, then the ALLRED-exit rule forces emerg_phase.
  - emerg_phase ≥ NUM_PHASES is treated as emerg=0.
- FLASH exits when flash_mode=0 or a valid emerg=1 appears. Exit goes to ALLRED with a full T_ALLRED; the next phase is then chosen by the normal rule.

## Timing
- Reset values:
  - State ALLRED, timer 0, active_phase=NUM_PHASES-1, pend=0, flash_tgl=0.
  - light is all 100, so all approaches are red; state_o=2.
- light, active_phase and state_o are registered. They change only on clk edges, one cycle after the deciding condition is sampled.
- A req sampled at edge k is eligible for the ALLRED exit decision at edge k+1 or later.
- Fixed-time cycle length per phase: T_GREEN+T_YELLOW+T_ALLRED cycles, which is 10 with defaults.
- rst asserted mid-operation overrides everything on that edge. All lamps go red on the next edge and pend is discarded.
- Green is never shown to two phases at once. A green→green transition always passes through YELLOW and ALLRED.

## Structure
- Shared package traffic_pkg holds:
  - the state enum;
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
- One combinational sub-module, rr_phase_select (parameter NUM_PHASES):
  - inputs: pend, current phase;
  - outputs: next pending phase plus a found flag.
- The FSM, timer, pend register and lamp decode stay in the top module.

## Test plan
All scenarios use default parameters.
- **Reset, no demand:** rst for 2 cycles, then release. Expect 1 cycle all-red, then phase 0 green for 7 cycles, yellow 2, all-red 1, then phase 1 green. Sequence wraps 3→0 after 40 cycles.
- **Demand skip:** pulse req=4'b0100 for 1 cycle during phase 0 green. After phase 0 all-red, phase 2 goes green (phase 1 skipped) and pend[2] clears on green entry.
- **Emergency pre-emption:** assert emerg=1, emerg_phase=3 at timer=3 of phase 0 green. Expect yellow on the next edge, yellow for 2 cycles, all-red for 1, then phase 3 green held while emerg=1. After release, exactly 7 more green cycles.
- **Flash mode:** set flash_mode=1 during phase 1 green. After that phase's all-red, all lamps alternate 010/000 each cycle. Clearing flash_mode gives 1 cycle all-red, then the next round-robin phase goes green.
- **Invalid emergency:** emerg=1 with emerg_phase=5 has no effect (requires an emerg_phase width of 3, e.g. NUM_PHASES=5 with emerg_phase=7). Fixed-time sequence continues unchanged.
- **Reset mid-operation:** rst during phase 2 yellow with pend=4'b1010. Next edge gives all-red and pend=0, and the sequence restarts at phase 0 after 1 all-red cycle.
